multichannel_linear_interpolator: RTL and testbench
===================================================

Name: multichannel_linear_interpolator

Overview:
Parametrised successor to the stereo linear interpolator. Resamples NUM_CH channels of signed audio, arriving on an asynchronous-rate strobe, onto a fixed output tick every OUT_PERIOD clocks. One time-multiplexed multiplier serves all channels. Results are unnormalised: y = d0*a + d1*(N-a), emitted with N so the downstream normaliser can scale them. Sits between the I2S/SPDIF capture and the output FIFO.

Parameters:
NUM_CH, 2, channel count (1..8)
DATA_W, 24, signed input sample width
CNT_W, 11, phase/period counter width
OUT_PERIOD, 512, clocks per output tick (96 kHz at 49.152 MHz); must exceed LATENCY
MULT_LAT, 2, multiplier pipeline depth in clocks
OUT_W (derived), DATA_W+CNT_W+1, signed output width
LATENCY (derived), 2*NUM_CH+MULT_LAT+3

Ports:
clk  in  1  system clock (mclk domain)
reset  in  1  asynchronous, active-high reset
run  in  1  synchronous enable; low = idle and clear
din_en  in  1  one-clock strobe; new frame on din
din  in  NUM_CH*DATA_W  channel k at bits [k*DATA_W +: DATA_W], signed
dout_valid  out  1  one-clock pulse; dout and dout_period valid
dout  out  NUM_CH*OUT_W  interpolated sums, same packing, signed
dout_period  out  CNT_W  N used for this output
stall  out  1  input counter saturated (no strobe for 2^CNT_W-1 clocks)
primed  out  1  at least two frames captured since run rose
test_data  out  16  {state[2:0], din_en, tick, a[10:0] truncated/zero-padded}

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high. Reset clears every register; all outputs are 0.
- run low (synchronous): clears counters, history, primed, stall and state (goes to IDLE). Aborts any in-flight computation with no dout_valid. Held registers on dout keep their values.
- History: on din_en, d1[k] <= d0[k], d0[k] <= din[k], period N <= in_cnt+1 (saturating), in_cnt <= 0. A frame counter sets primed on the second strobe.
- Phase counter: otherwise in_cnt increments and saturates at 2^CNT_W-1. At saturation stall = 1; it clears on the next din_en.
- Tick: tick_cnt counts 0..OUT_PERIOD-1 while run is high. tick is a registered one-clock pulse at wrap.
- State machine:
  - IDLE: on tick, go to LOAD.
  - LOAD (1 clk): snapshot d0/d1 for all channels, N, a = min(in_cnt, N), and compute b = N-a (never negative). A din_en coincident with the tick cycle is already applied, so a = 0.
  - ISSUE (2*NUM_CH clks): even slot 2k issues d0[k]*a; odd slot 2k+1 issues d1[k]*b. Operands are sign-extended; coefficients are unsigned and zero-extended.
  - DRAIN (MULT_LAT clks).
  - OUT (1 clk): dout_valid = 1; dout and dout_period update in the same cycle.
  - Then return to IDLE.
- Accumulation: each product adds into acc[k] (OUT_W bits, signed); acc[k] is cleared in LOAD. No overflow is possible by width.
- Latency: dout_valid rises exactly LATENCY clocks after the tick cycle (9 for defaults).
- Snapshot isolation: din_en during ISSUE/DRAIN does not affect the current result.
- primed = 0: dout_valid still pulses; the data is whatever the history holds (zeros after reset/run).
- stall = 1: computation proceeds unchanged (a clamped to N). Downstream decides whether to mute.
- tick while not IDLE cannot occur because OUT_PERIOD > LATENCY is enforced by an elaboration-time check.

Decomposition:
- Shared package interp_pkg: state encoding (IDLE, LOAD, ISSUE, DRAIN, OUT), the OUT_W/LATENCY derivation functions, and the channel slice helper.
- One sub-module, interp_mac: signed DATA_W x unsigned CNT_W pipelined multiplier (MULT_LAT stages, CE-free) feeding the accumulator add. It is instantiated once and shared by all channels.

Test Plan:
- Basic interpolation (NUM_CH=2, OUT_PERIOD=16): strobes every 8 clks with ch0 1000 then 2000 and ch1 -1000 then 1000, tick arriving with a=3 -> dout ch0 = 11000, ch1 = -2000, dout_period = 8, dout_valid 9 clks after tick.
- Coincident strobe and tick: din_en in the tick cycle -> a = 0, so ch0 dout = d1*N using the new d1 (previous d0).
- Phase clamp: in_cnt = 10 with N = 8 -> a = 8, b = 0, and ch0 dout = d0*8.
- Stall: no din_en for 2047 clks -> stall = 1, in_cnt holds at 2047, outputs continue; the next din_en clears stall and sets N = 2047.
- Abort: run dropped mid-ISSUE -> no dout_valid, state IDLE, primed = 0. Re-run with two strobes -> primed = 1 and correct results.
- Async reset mid-DRAIN -> all outputs 0 immediately, before any clk edge. After release, normal operation resumes at the next tick.

Source files
------------

// File: rtl/interp_pkg.sv
// Shared definitions for the multichannel linear interpolator.
//   state_t  : controller states (IDLE, LOAD, ISSUE, DRAIN, OUT)
//   out_w    : signed result width for a DATA_W x CNT_W product sum
//   latency  : clocks from the tick cycle to dout_valid
//   ch_lsb   : LSB position of channel k in a packed multichannel bus
package interp_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ISSUE = 3'd2,
    DRAIN = 3'd3,
    OUT   = 3'd4
  } state_t;

  localparam int unsigned TEST_A_W = 11;

  function automatic int unsigned out_w(input int unsigned data_w, input int unsigned cnt_w);
    return data_w + cnt_w + 1;
  endfunction

  function automatic int unsigned latency(input int unsigned num_ch, input int unsigned mult_lat);
    return 2 * num_ch + mult_lat + 3;
  endfunction

  function automatic int unsigned ch_lsb(input int unsigned k, input int unsigned w);
    return k * w;
  endfunction

endpackage

// File: rtl/interp_mac.sv
// Shared pipelined multiplier: signed DATA_W operand times unsigned CNT_W
// coefficient, MULT_LAT register stages, no clock enable. A valid flag and a
// channel tag travel alongside the product so the caller knows where to
// accumulate it.
//   clk, reset : clock, asynchronous active-high reset
//   op         : signed sample operand
//   coef       : unsigned interpolation coefficient
//   in_valid   : operand pair is a real product
//   in_tag     : channel index for this product
//   prod       : signed product, out_w(DATA_W, CNT_W) bits
//   out_valid  : prod is a real product
//   out_tag    : channel index delayed with prod
module interp_mac
  import interp_pkg::*;
#(
  parameter int unsigned DATA_W   = 24,
  parameter int unsigned CNT_W    = 11,
  parameter int unsigned MULT_LAT = 2,
  parameter int unsigned TAG_W    = 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [DATA_W-1:0]                  op,
  input  logic [CNT_W-1:0]                   coef,
  input  logic                               in_valid,
  input  logic [TAG_W-1:0]                   in_tag,
  output logic [out_w(DATA_W, CNT_W)-1:0]    prod,
  output logic                               out_valid,
  output logic [TAG_W-1:0]                   out_tag
);

  localparam int unsigned PROD_W = out_w(DATA_W, CNT_W);

  logic signed [PROD_W-1:0] op_x;
  logic signed [PROD_W-1:0] coef_x;
  logic        [PROD_W-1:0] pipe [MULT_LAT];
  logic                     vld  [MULT_LAT];
  logic        [TAG_W-1:0]  tag  [MULT_LAT];

  // Operand sign-extended, coefficient zero-extended, so a plain signed
  // multiply at full result width gives the exact product.
  always_comb begin
    op_x   = PROD_W'($signed(op));
    coef_x = PROD_W'(coef);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < MULT_LAT; i++) begin
        pipe[i] <= '0;
        vld[i]  <= 1'b0;
        tag[i]  <= '0;
      end
    end else begin
      pipe[0] <= op_x * coef_x;
      vld[0]  <= in_valid;
      tag[0]  <= in_tag;
      for (int unsigned i = 1; i < MULT_LAT; i++) begin
        pipe[i] <= pipe[i-1];
        vld[i]  <= vld[i-1];
        tag[i]  <= tag[i-1];
      end
    end
  end

  always_comb begin
    prod      = pipe[MULT_LAT-1];
    out_valid = vld[MULT_LAT-1];
    out_tag   = tag[MULT_LAT-1];
  end

endmodule

// File: rtl/multichannel_linear_interpolator.sv
// Multichannel linear interpolator. Resamples NUM_CH signed channels arriving
// on din_en onto a fixed output tick every OUT_PERIOD clocks, producing the
// unnormalised sum y = d0*a + d1*(N-a) together with N.
//   clk, reset  : clock, asynchronous active-high reset
//   run         : synchronous enable; low idles and clears
//   din_en, din : input frame strobe and packed signed samples
//   dout_valid  : one-clock pulse; dout/dout_period valid
//   dout        : packed signed interpolated sums
//   dout_period : N used for this output
//   stall       : input phase counter saturated
//   primed      : two frames captured since run rose
//   test_data   : {state, din_en, tick, a[10:0]}
module multichannel_linear_interpolator
  import interp_pkg::*;
#(
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned DATA_W     = 24,
  parameter int unsigned CNT_W      = 11,
  parameter int unsigned OUT_PERIOD = 512,
  parameter int unsigned MULT_LAT   = 2
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    run,
  input  logic                                    din_en,
  input  logic [NUM_CH*DATA_W-1:0]                din,
  output logic                                    dout_valid,
  output logic [NUM_CH*out_w(DATA_W, CNT_W)-1:0]  dout,
  output logic [CNT_W-1:0]                        dout_period,
  output logic                                    stall,
  output logic                                    primed,
  output logic [15:0]                             test_data
);

  localparam int unsigned OUT_W   = out_w(DATA_W, CNT_W);
  localparam int unsigned LATENCY = latency(NUM_CH, MULT_LAT);
  localparam int unsigned SEQ_MAX = (2 * NUM_CH > MULT_LAT) ? 2 * NUM_CH : MULT_LAT;
  localparam int unsigned SEQ_W   = $clog2(SEQ_MAX + 1);
  localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned TICK_W  = (OUT_PERIOD > 1) ? $clog2(OUT_PERIOD) : 1;

  localparam logic [CNT_W-1:0]  CNT_MAX    = '1;
  localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(OUT_PERIOD - 1);
  localparam logic [SEQ_W-1:0]  ISSUE_LAST = SEQ_W'(2 * NUM_CH - 1);
  localparam logic [SEQ_W-1:0]  DRAIN_LAST = SEQ_W'(MULT_LAT - 1);

  if (OUT_PERIOD <= LATENCY) begin : g_bad_period
    $error("OUT_PERIOD must exceed the interpolator latency");
  end
  if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_ch
    $error("NUM_CH must be in 1..8");
  end
  if (MULT_LAT < 1) begin : g_bad_lat
    $error("MULT_LAT must be at least 1");
  end

  state_t state, state_next;

  logic [TICK_W-1:0] tick_cnt;
  logic              tick;

  logic signed [DATA_W-1:0] d0 [NUM_CH];
  logic signed [DATA_W-1:0] d1 [NUM_CH];
  logic [CNT_W-1:0]         in_cnt;
  logic [CNT_W-1:0]         n_period;
  logic                     seen_one;
  logic                     primed_q;

  logic signed [DATA_W-1:0] d0s [NUM_CH];
  logic signed [DATA_W-1:0] d1s [NUM_CH];
  logic [CNT_W-1:0]         n_s;
  logic [CNT_W-1:0]         a_s;
  logic [CNT_W-1:0]         b_s;
  logic [CNT_W-1:0]         a_now;

  logic [SEQ_W-1:0]         seq_cnt;
  logic [CH_W-1:0]          ch_sel;
  logic [DATA_W-1:0]        mac_op;
  logic [CNT_W-1:0]         mac_coef;
  logic                     mac_in_valid;
  logic [OUT_W-1:0]         mac_prod;
  logic                     mac_out_valid;
  logic [CH_W-1:0]          mac_out_ch;

  logic signed [OUT_W-1:0]  acc [NUM_CH];
  logic [TEST_A_W-1:0]      a_field;

  // Output tick generator
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt <= '0;
      tick     <= 1'b0;
    end else if (!run) begin
      tick_cnt <= '0;
      tick     <= 1'b0;
    end else begin
      tick <= (tick_cnt == TICK_LAST);
      if (tick_cnt == TICK_LAST) tick_cnt <= '0;
      else                       tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // Input history and phase counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        d0[k] <= '0;
        d1[k] <= '0;
      end
      in_cnt   <= '0;
      n_period <= '0;
      seen_one <= 1'b0;
      primed_q <= 1'b0;
    end else if (!run) begin
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        d0[k] <= '0;
        d1[k] <= '0;
      end
      in_cnt   <= '0;
      n_period <= '0;
      seen_one <= 1'b0;
      primed_q <= 1'b0;
    end else if (din_en) begin
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        d1[k] <= d0[k];
        d0[k] <= din[ch_lsb(k, DATA_W) +: DATA_W];
      end
      n_period <= (in_cnt == CNT_MAX) ? CNT_MAX : in_cnt + 1'b1;
      in_cnt   <= '0;
      seen_one <= 1'b1;
      primed_q <= primed_q | seen_one;
    end else if (in_cnt != CNT_MAX) begin
      in_cnt <= in_cnt + 1'b1;
    end
  end

  always_comb begin
    stall  = (in_cnt == CNT_MAX);
    primed = primed_q;
    a_now  = (in_cnt < n_period) ? in_cnt : n_period;
  end

  // Controller
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (!run) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (tick) state_next = LOAD;
        LOAD:    state_next = ISSUE;
        ISSUE:   if (seq_cnt == ISSUE_LAST) state_next = DRAIN;
        DRAIN:   if (seq_cnt == DRAIN_LAST) state_next = OUT;
        OUT:     state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Slot counter: restarts on every state change, runs only in ISSUE/DRAIN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seq_cnt <= '0;
    end else if (state_next != state || !(state == ISSUE || state == DRAIN)) begin
      seq_cnt <= '0;
    end else begin
      seq_cnt <= seq_cnt + 1'b1;
    end
  end

  // Snapshot taken at the end of LOAD; later strobes only touch d0/d1
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        d0s[k] <= '0;
        d1s[k] <= '0;
      end
      n_s <= '0;
      a_s <= '0;
      b_s <= '0;
    end else if (!run) begin
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        d0s[k] <= '0;
        d1s[k] <= '0;
      end
      n_s <= '0;
      a_s <= '0;
      b_s <= '0;
    end else if (state == LOAD) begin
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        d0s[k] <= d0[k];
        d1s[k] <= d1[k];
      end
      n_s <= n_period;
      a_s <= a_now;
      b_s <= n_period - a_now;
    end
  end

  // Even slot 2k: d0[k]*a, odd slot 2k+1: d1[k]*b
  always_comb begin
    ch_sel       = CH_W'(seq_cnt >> 1);
    mac_op       = seq_cnt[0] ? d1s[ch_sel] : d0s[ch_sel];
    mac_coef     = seq_cnt[0] ? b_s : a_s;
    mac_in_valid = run && (state == ISSUE);
  end

  interp_mac #(
    .DATA_W   (DATA_W),
    .CNT_W    (CNT_W),
    .MULT_LAT (MULT_LAT),
    .TAG_W    (CH_W)
  ) u_mac (
    .clk       (clk),
    .reset     (reset),
    .op        (mac_op),
    .coef      (mac_coef),
    .in_valid  (mac_in_valid),
    .in_tag    (ch_sel),
    .prod      (mac_prod),
    .out_valid (mac_out_valid),
    .out_tag   (mac_out_ch)
  );

  // The accumulate is its own register stage after the multiplier, which is
  // where the +3 in the latency comes from (LOAD, accumulate, output reg).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned k = 0; k < NUM_CH; k++) acc[k] <= '0;
    end else if (!run || state == LOAD) begin
      for (int unsigned k = 0; k < NUM_CH; k++) acc[k] <= '0;
    end else if (mac_out_valid) begin
      acc[mac_out_ch] <= acc[mac_out_ch] + $signed(mac_prod);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout_valid  <= 1'b0;
      dout        <= '0;
      dout_period <= '0;
    end else begin
      dout_valid <= run && (state == OUT);
      if (run && state == OUT) begin
        for (int unsigned k = 0; k < NUM_CH; k++) begin
          dout[ch_lsb(k, OUT_W) +: OUT_W] <= acc[k];
        end
        dout_period <= n_s;
      end
    end
  end

  if (CNT_W >= TEST_A_W) begin : g_a_trunc
    assign a_field = a_s[TEST_A_W-1:0];
  end else begin : g_a_pad
    assign a_field = {{(TEST_A_W - CNT_W){1'b0}}, a_s};
  end

  assign test_data = {state, din_en, tick, a_field};

endmodule

// File: tb/tb_multichannel_linear_interpolator.sv
// Directed bench for multichannel_linear_interpolator (NUM_CH=2, OUT_PERIOD=16).
// Edge Ei is the i-th rising clk edge after run rises; the tick lands after
// E15 and E31, so the second output (LOAD at E32) appears after E40.
module tb_multichannel_linear_interpolator;

  localparam int unsigned NUM_CH     = 2;
  localparam int unsigned DATA_W     = 24;
  localparam int unsigned CNT_W      = 11;
  localparam int unsigned OUT_PERIOD = 16;
  localparam int unsigned MULT_LAT   = 2;
  localparam int unsigned OUT_W      = DATA_W + CNT_W + 1;

  logic                       clk;
  logic                       reset;
  logic                       run;
  logic                       din_en;
  logic [NUM_CH*DATA_W-1:0]   din;
  logic                       dout_valid;
  logic [NUM_CH*OUT_W-1:0]    dout;
  logic [CNT_W-1:0]           dout_period;
  logic                       stall;
  logic                       primed;
  logic [15:0]                test_data;

  multichannel_linear_interpolator #(
    .NUM_CH     (NUM_CH),
    .DATA_W     (DATA_W),
    .CNT_W      (CNT_W),
    .OUT_PERIOD (OUT_PERIOD),
    .MULT_LAT   (MULT_LAT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .din_en      (din_en),
    .din         (din),
    .dout_valid  (dout_valid),
    .dout        (dout),
    .dout_period (dout_period),
    .stall       (stall),
    .primed      (primed),
    .test_data   (test_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int     f1_0, f1_1;
    int     f2_0, f2_1;
    int     cnt;
    int     n;
    longint e0, e1;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string nm, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  function automatic longint ch_out(input int k);
    logic signed [OUT_W-1:0] t;
    t = dout[k*OUT_W +: OUT_W];
    return longint'(t);
  endfunction

  function automatic logic [NUM_CH*DATA_W-1:0] frame(input int c0, input int c1);
    logic [DATA_W-1:0] a, b;
    a = DATA_W'(c0);
    b = DATA_W'(c1);
    return {b, a};
  endfunction

  // Drive inputs for the next edge, take it, sample 1 time unit later.
  task automatic step(input logic en, input logic [NUM_CH*DATA_W-1:0] f);
    din_en = en;
    din    = f;
    @(posedge clk);
    #1;
  endtask

  task automatic restart_run();
    run = 1'b0;
    step(1'b0, '0);
    step(1'b0, '0);
    run = 1'b1;
  endtask

  task automatic apply_vec(input int idx);
    vec_t v;
    int s1, s2, a_exp;
    v     = vecs[idx];
    s2    = 32 - v.cnt;
    s1    = s2 - v.n;
    a_exp = (v.cnt < v.n) ? v.cnt : v.n;
    restart_run();
    for (int i = 0; i <= 40; i++) begin
      if (i == s1)      step(1'b1, frame(v.f1_0, v.f1_1));
      else if (i == s2) step(1'b1, frame(v.f2_0, v.f2_1));
      else              step(1'b0, '0);
      if (i == 0)  check($sformatf("v%0d primed_start", idx), primed, 0);
      if (i == 33) check($sformatf("v%0d a_snap", idx), test_data[10:0], a_exp);
      if (i == 39) check($sformatf("v%0d valid_early", idx), dout_valid, 0);
      if (i == 40) begin
        check($sformatf("v%0d valid", idx), dout_valid, 1);
        check($sformatf("v%0d ch0", idx), ch_out(0), v.e0);
        check($sformatf("v%0d ch1", idx), ch_out(1), v.e1);
        check($sformatf("v%0d period", idx), dout_period, v.n);
        check($sformatf("v%0d primed", idx), primed, 1);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected end of stimulus");
    $fatal(1);
  end

  initial begin
    int pulses;
    //          f1 ch0     f1 ch1    f2 ch0     f2 ch1    cnt  N   exp ch0    exp ch1
    vecs[0] = '{1000,      -1000,    2000,      1000,     3,   8,  11000,     -2000};
    vecs[1] = '{500,       -7,       9999,      123,      0,   8,  4000,      -56};
    vecs[2] = '{-3,        4,        100,       -25,      10,  8,  800,       -200};
    vecs[3] = '{-8388608,  8388607,  8388607,   -8388608, 5,   12, -16777221, 16777209};
    vecs[4] = '{7,         11,       -9,        3,        6,   6,  -54,       18};
    vecs[5] = '{1,         -2,       3,         4,        2,   20, 24,        -28};

    reset  = 1'b0;
    run    = 1'b0;
    din_en = 1'b0;
    din    = '0;
    #1 reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst valid",     dout_valid, 0);
    check("rst ch0",       ch_out(0), 0);
    check("rst ch1",       ch_out(1), 0);
    check("rst period",    dout_period, 0);
    check("rst stall",     stall, 0);
    check("rst primed",    primed, 0);
    check("rst test_data", test_data, 0);
    reset = 1'b0;

    for (int v = 0; v < 6; v++) apply_vec(v);

    // Stall: strobe at E0, silence until E2053
    restart_run();
    pulses = 0;
    for (int i = 0; i <= 2072; i++) begin
      if (i == 0)         step(1'b1, frame(5, -5));
      else if (i == 2053) step(1'b1, frame(2, 3));
      else                step(1'b0, '0);
      if (i <= 2047 && dout_valid) pulses++;
      if (i == 2046) check("stall before sat", stall, 0);
      if (i == 2047) check("stall at sat", stall, 1);
      if (i == 2052) check("stall held", stall, 1);
      if (i == 2053) check("stall cleared", stall, 0);
      if (i == 2056) begin
        check("stall out valid", dout_valid, 1);
        check("stall out period", dout_period, 1);
        check("stall out ch0", ch_out(0), 5);
        check("stall out ch1", ch_out(1), -5);
      end
      if (i == 2072) begin
        check("post stall valid", dout_valid, 1);
        check("post stall period", dout_period, 2047);
        check("post stall ch0", ch_out(0), 10202);
        check("post stall ch1", ch_out(1), -10147);
      end
    end
    check("stall pulse count", pulses, 127);

    // Abort: run dropped while in ISSUE
    restart_run();
    for (int i = 0; i <= 18; i++) begin
      if (i == 2)      step(1'b1, frame(50, 60));
      else if (i == 6) step(1'b1, frame(70, 80));
      else             step(1'b0, '0);
      if (i == 6)  check("abort primed", primed, 1);
      if (i == 18) check("abort in issue", test_data[15:13], 2);
    end
    run = 1'b0;
    pulses = 0;
    for (int j = 0; j < 16; j++) begin
      step(1'b0, '0);
      if (dout_valid) pulses++;
      if (j == 0) begin
        check("abort state idle", test_data[15:13], 0);
        check("abort primed clr", primed, 0);
      end
    end
    check("abort no valid", pulses, 0);
    check("abort hold ch0", ch_out(0), 10202);
    check("abort hold ch1", ch_out(1), -10147);
    check("abort hold period", dout_period, 2047);
    apply_vec(0);

    // Asynchronous reset during DRAIN
    restart_run();
    for (int i = 0; i <= 21; i++) begin
      if (i == 2)      step(1'b1, frame(100, 200));
      else if (i == 6) step(1'b1, frame(300, 400));
      else             step(1'b0, '0);
    end
    check("pre reset drain", test_data[15:13], 3);
    reset = 1'b1;
    #1;
    check("arst valid",     dout_valid, 0);
    check("arst ch0",       ch_out(0), 0);
    check("arst ch1",       ch_out(1), 0);
    check("arst period",    dout_period, 0);
    check("arst primed",    primed, 0);
    check("arst stall",     stall, 0);
    check("arst test_data", test_data, 0);
    #1 reset = 1'b0;
    for (int i = 0; i <= 24; i++) begin
      if (i == 2)      step(1'b1, frame(10, 20));
      else if (i == 6) step(1'b1, frame(30, 40));
      else             step(1'b0, '0);
      if (i == 23) check("resume valid early", dout_valid, 0);
      if (i == 24) begin
        check("resume valid",  dout_valid, 1);
        check("resume ch0",    ch_out(0), 120);
        check("resume ch1",    ch_out(1), 160);
        check("resume period", dout_period, 4);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
